// File: rtl/hec_issuer_pkg.sv
// Shared constants and types for the coprocessor instruction issuer.
// Covers the NOP/spacer words, the FSM encoding and the instruction word layout.
package hec_issuer_pkg;

   localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
   localparam logic [31:0] SPACER_WORD = 32'h0000_0001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SPACER,
      ST_WAIT_LOW,
      ST_WAIT_HIGH,
      ST_ERROR
   } state_e;

   // Instruction word layout: |wtM1|wtM0|rdM1|rdM0|rsvd|mod|inst|
   typedef struct packed {
      logic [3:0] wtm1;
      logic [3:0] wtm0;
      logic [3:0] rdm1;
      logic [3:0] rdm0;
      logic [6:0] rsvd;
      logic       mod;
      logic [7:0] inst;
   } inst_fields_t;

   function automatic logic [31:0] spacer_for(input logic [31:0] held);
      return (held == NOP_WORD) ? SPACER_WORD : NOP_WORD;
   endfunction

endpackage

// File: rtl/issuer_fifo.sv
// First-word-fall-through instruction FIFO with synchronous flush.
// A write while full is taken only when a read frees a slot in the same cycle.
module issuer_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   input  logic         flush,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_wr, do_rd;

   assign full    = (cnt_q == FULL_CNT);
   assign empty   = (cnt_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_rd    = rd_en && !empty && !flush;
      do_wr    = wr_en && !flush && (!full || do_rd);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_wr && !do_rd) cnt_d = cnt_q + 1'b1;
         if (do_rd && !do_wr) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/inst_issuer.sv
// Issues queued instruction words to the interfacer one at a time,
// pacing each on the done bit dropping and returning.
module inst_issuer
   import hec_issuer_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int ACK_LOW_MAX = 4,
   parameter int TIMEOUT_W   = 24
) (
   input  logic        bram_clk_a,
   input  logic        bram_rst_a,
   input  logic [31:0] cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        flush,
   input  logic        clear_err,
   output logic [31:0] inst_word,
   input  logic        inst_done,
   output logic        busy,
   output logic [15:0] issued_cnt,
   output logic        err_noack,
   output logic        err_timeout
);

   localparam int ACK_W = (ACK_LOW_MAX < 1) ? 1 : $clog2(ACK_LOW_MAX + 1);
   localparam logic [ACK_W-1:0] ACK_LIM = ACK_W'(ACK_LOW_MAX);
   localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W - 1){1'b1}}, 1'b0};

   state_e                state_q, state_d;
   logic [31:0]           word_q, word_d;
   logic [31:0]           held_q, held_d;
   logic                  held_vld_q, held_vld_d;
   logic [ACK_W-1:0]      ack_cnt_q, ack_cnt_d;
   logic [TIMEOUT_W-1:0]  to_cnt_q, to_cnt_d;
   logic [15:0]           issued_q, issued_d;
   logic                  noack_q, noack_d;
   logic                  tmo_q, tmo_d;

   logic [31:0] head;
   logic        fifo_full, fifo_empty, fifo_pop, fifo_avail;

   issuer_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (32)
   ) u_fifo (
      .clk     (bram_clk_a),
      .rst     (bram_rst_a),
      .wr_en   (cmd_valid),
      .wr_data (cmd_data),
      .rd_en   (fifo_pop),
      .flush   (flush),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign fifo_avail  = !fifo_empty && !flush;
   assign cmd_ready   = !fifo_full;
   assign inst_word   = word_q;
   assign issued_cnt  = issued_q;
   assign err_noack   = noack_q;
   assign err_timeout = tmo_q;
   assign busy = ((state_q != ST_IDLE) && (state_q != ST_ERROR)) || !fifo_empty;

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      held_d     = held_q;
      held_vld_d = held_vld_q;
      ack_cnt_d  = ack_cnt_q;
      to_cnt_d   = to_cnt_q;
      issued_d   = issued_q;
      noack_d    = noack_q;
      tmo_d      = tmo_q;
      fifo_pop   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fifo_avail && inst_done) begin
               fifo_pop  = 1'b1;
               ack_cnt_d = '0;
               // An unchanged word would not be seen; park it behind a spacer.
               if (head == word_q) begin
                  held_d     = head;
                  held_vld_d = 1'b1;
                  state_d    = ST_SPACER;
               end else begin
                  word_d  = head;
                  state_d = ST_WAIT_LOW;
               end
            end
         end
         ST_SPACER: begin
            word_d    = spacer_for(held_q);
            ack_cnt_d = '0;
            state_d   = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            if (!inst_done) begin
               to_cnt_d = '0;
               state_d  = ST_WAIT_HIGH;
            end else if (ack_cnt_q == ACK_LIM) begin
               noack_d = 1'b1;
               state_d = ST_ERROR;
            end else begin
               ack_cnt_d = ack_cnt_q + 1'b1;
            end
         end
         ST_WAIT_HIGH: begin
            if (inst_done) begin
               issued_d = issued_q + 16'd1;
               if (held_vld_q) begin
                  word_d     = held_q;
                  held_vld_d = 1'b0;
                  ack_cnt_d  = '0;
                  state_d    = ST_WAIT_LOW;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (to_cnt_q == TO_LAST) begin
               to_cnt_d = to_cnt_q + 1'b1;
               tmo_d    = 1'b1;
               state_d  = ST_ERROR;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_ERROR: begin
         end
         default: state_d = ST_IDLE;
      endcase
      // Clearing also overrides an error raised in the same cycle.
      if (clear_err) begin
         noack_d = 1'b0;
         tmo_d   = 1'b0;
         if (state_d == ST_ERROR) begin
            state_d    = ST_IDLE;
            held_vld_d = 1'b0;
            ack_cnt_d  = '0;
            to_cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge bram_clk_a or posedge bram_rst_a) begin
      if (bram_rst_a) begin
         state_q    <= ST_IDLE;
         word_q     <= NOP_WORD;
         held_q     <= NOP_WORD;
         held_vld_q <= 1'b0;
         ack_cnt_q  <= '0;
         to_cnt_q   <= '0;
         issued_q   <= '0;
         noack_q    <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         held_q     <= held_d;
         held_vld_q <= held_vld_d;
         ack_cnt_q  <= ack_cnt_d;
         to_cnt_q   <= to_cnt_d;
         issued_q   <= issued_d;
         noack_q    <= noack_d;
         tmo_q      <= tmo_d;
      end
   end

endmodule

// File: tb/tb_inst_issuer.sv
// Directed bench for inst_issuer with a behavioural interfacer/coprocessor
// whose done latency is set per scenario.
module tb_inst_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cmd_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        flush;
   logic        clear_err;
   logic [31:0] inst_word;
   logic        inst_done;
   logic        busy;
   logic [15:0] issued_cnt;
   logic        err_noack;
   logic        err_timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   inst_issuer #(
      .FIFO_DEPTH  (16),
      .ACK_LOW_MAX (4),
      .TIMEOUT_W   (6)
   ) dut (
      .bram_clk_a  (clk),
      .bram_rst_a  (rst),
      .cmd_data    (cmd_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .flush       (flush),
      .clear_err   (clear_err),
      .inst_word   (inst_word),
      .inst_done   (inst_done),
      .busy        (busy),
      .issued_cnt  (issued_cnt),
      .err_noack   (err_noack),
      .err_timeout (err_timeout)
   );

   // Interfacer model: drops done one cycle after a word change, raises it lat cycles later.
   logic [31:0] seen;
   int          left;
   bit          never_drop;
   int          lat;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         seen      <= '0;
         left      <= 0;
         inst_done <= 1'b1;
      end else if (never_drop) begin
         seen <= inst_word;
      end else if (inst_word != seen) begin
         seen      <= inst_word;
         inst_done <= 1'b0;
         left      <= lat;
      end else if (!inst_done) begin
         if (left <= 1) inst_done <= 1'b1;
         else left <= left - 1;
      end
   end

   // Log of every distinct word driven to the interfacer.
   logic [31:0] prev;
   logic [31:0] log_q[$];

   always @(negedge clk) begin
      if (rst) prev = '0;
      else begin
         if (inst_word !== prev) log_q.push_back(inst_word);
         prev = inst_word;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset(input int l);
      lat        = l;
      never_drop = 0;
      flush      = 1'b0;
      clear_err  = 1'b0;
      cmd_valid  = 1'b0;
      cmd_data   = '0;
      rst        = 1'b1;
      repeat (2) @(negedge clk);
      log_q.delete();
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] w);
      cmd_data  = w;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: busy=%b after %0d cycles, required 0", tag, busy, budget);
      end
   endtask

   task automatic test_reset;
      lat        = 10;
      never_drop = 0;
      flush      = 1'b0;
      clear_err  = 1'b0;
      cmd_valid  = 1'b0;
      cmd_data   = '0;
      rst        = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (inst_word !== 32'h0) begin
         bad++;
         $display("FAIL reset_word: got %h, required 0", inst_word);
      end
      total++;
      if ({cmd_ready, busy, err_noack, err_timeout} !== 4'b1000) begin
         bad++;
         $display("FAIL reset_flags: ready/busy/noack/tmo=%b, required 1000",
                  {cmd_ready, busy, err_noack, err_timeout});
      end
      total++;
      if (issued_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_cnt: got %0d, required 0", issued_cnt);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_two_words;
      do_reset(10);
      push(32'h0011_0102);
      push(32'h2200_0103);
      wait_idle(300, "two_idle");
      total++;
      if (log_q.size() != 2 || log_q[0] !== 32'h0011_0102 || log_q[1] !== 32'h2200_0103) begin
         bad++;
         $display("FAIL two_seq: got %p, required 00110102,22000103", log_q);
      end
      total++;
      if (issued_cnt !== 16'd2) begin
         bad++;
         $display("FAIL two_cnt: got %0d, required 2", issued_cnt);
      end
      total++;
      if (inst_word !== 32'h2200_0103) begin
         bad++;
         $display("FAIL two_word: got %h, required 22000103", inst_word);
      end
   endtask

   task automatic test_repeat;
      do_reset(10);
      push(32'h0011_0102);
      push(32'h0011_0102);
      wait_idle(300, "rep_idle");
      total++;
      if (log_q.size() != 3 || log_q[0] !== 32'h0011_0102 || log_q[1] !== 32'h0
          || log_q[2] !== 32'h0011_0102) begin
         bad++;
         $display("FAIL rep_seq: got %p, required 00110102,0,00110102", log_q);
      end
      total++;
      if (issued_cnt !== 16'd3) begin
         bad++;
         $display("FAIL rep_cnt: got %0d, required 3", issued_cnt);
      end
   endtask

   task automatic test_nop;
      do_reset(10);
      push(32'h0);
      wait_idle(300, "nop_idle");
      total++;
      if (log_q.size() != 2 || log_q[0] !== 32'h1 || log_q[1] !== 32'h0) begin
         bad++;
         $display("FAIL nop_seq: got %p, required 1,0", log_q);
      end
      total++;
      if (issued_cnt !== 16'd2) begin
         bad++;
         $display("FAIL nop_cnt: got %0d, required 2", issued_cnt);
      end
   endtask

   task automatic test_noack;
      int n;
      do_reset(10);
      never_drop = 1;
      push(32'h0000_0005);
      n = 0;
      while (inst_word !== 32'h5 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!err_noack && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n != 5) begin
         bad++;
         $display("FAIL noack_time: err after %0d cycles, required 5", n);
      end
      total++;
      if ({busy, err_timeout, cmd_ready} !== 3'b001) begin
         bad++;
         $display("FAIL noack_flags: busy/tmo/ready=%b, required 001",
                  {busy, err_timeout, cmd_ready});
      end
      push(32'h0000_0006);
      repeat (10) @(negedge clk);
      total++;
      if (inst_word !== 32'h5 || busy !== 1'b1) begin
         bad++;
         $display("FAIL noack_hold: word=%h busy=%b, required 5 and 1", inst_word, busy);
      end
      never_drop = 0;
      clear_err  = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      total++;
      if (err_noack !== 1'b0) begin
         bad++;
         $display("FAIL noack_clear: got %b, required 0", err_noack);
      end
      wait_idle(300, "noack_idle");
      total++;
      if (issued_cnt !== 16'd1 || inst_word !== 32'h6) begin
         bad++;
         $display("FAIL noack_resume: cnt=%0d word=%h, required 1 and 6", issued_cnt, inst_word);
      end
   endtask

   task automatic test_timeout;
      int n;
      do_reset(100);
      push(32'h0000_0007);
      n = 0;
      while (inst_word !== 32'h7 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!err_timeout && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n != 65) begin
         bad++;
         $display("FAIL tmo_time: err after %0d cycles, required 65", n);
      end
      push(32'h0000_0008);
      repeat (10) @(negedge clk);
      total++;
      if (inst_word !== 32'h7 || issued_cnt !== 16'd0 || err_timeout !== 1'b1) begin
         bad++;
         $display("FAIL tmo_hold: word=%h cnt=%0d tmo=%b, required 7, 0, 1",
                  inst_word, issued_cnt, err_timeout);
      end
      repeat (40) @(negedge clk);
      lat       = 10;
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      total++;
      if (err_timeout !== 1'b0) begin
         bad++;
         $display("FAIL tmo_clear: got %b, required 0", err_timeout);
      end
      wait_idle(300, "tmo_idle");
      total++;
      if (issued_cnt !== 16'd1 || inst_word !== 32'h8) begin
         bad++;
         $display("FAIL tmo_resume: cnt=%0d word=%h, required 1 and 8", issued_cnt, inst_word);
      end
   endtask

   task automatic test_flush;
      do_reset(40);
      cmd_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         cmd_data = 32'h100 + i;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_ready: got %b, required 0", cmd_ready);
      end
      cmd_data  = 32'hDEAD;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_ignore: ready=%b, required 0", cmd_ready);
      end
      flush     = 1'b1;
      cmd_data  = 32'hBEEF;
      cmd_valid = 1'b1;
      @(negedge clk);
      flush     = 1'b0;
      cmd_valid = 1'b0;
      total++;
      if (busy !== 1'b1 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_now: busy=%b ready=%b, required 1 and 1", busy, cmd_ready);
      end
      wait_idle(300, "flush_idle");
      total++;
      if (log_q.size() != 1 || log_q[0] !== 32'h100) begin
         bad++;
         $display("FAIL flush_seq: got %p, required 100", log_q);
      end
      total++;
      if (issued_cnt !== 16'd1 || inst_word !== 32'h100) begin
         bad++;
         $display("FAIL flush_cnt: cnt=%0d word=%h, required 1 and 100", issued_cnt, inst_word);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      do_reset(10);
      push(32'h0000_0009);
      push(32'h0000_000A);
      n = 0;
      while (inst_word !== 32'h9 && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (inst_word !== 32'h0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_out: word=%h busy=%b ready=%b, required 0, 0, 1",
                  inst_word, busy, cmd_ready);
      end
      total++;
      if (issued_cnt !== 16'd0 || err_noack !== 1'b0 || err_timeout !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_cnt: cnt=%0d noack=%b tmo=%b, required 0, 0, 0",
                  issued_cnt, err_noack, err_timeout);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_two_words();
      test_repeat();
      test_nop();
      test_noack();
      test_timeout();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
